wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 135 +++++++++++++
 tb/tb_wb_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: WB pipeline register, load formatting, result select, retire counter.
// Define WB_FWD_EN to compile in WB->EX forwarding; otherwise a hazard flag is raised instead.
module wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        ex_valid,
    input  logic        ex_Reg_WE,
    input  logic [4:0]  ex_AddrD,
    input  logic [1:0]  ex_WBSel,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_alu,
    input  logic [31:0] ex_pc,
    input  logic [31:0] mem_rdata,
    input  logic [4:0]  AddrA,
    input  logic [4:0]  AddrB,
    input  logic [31:0] rf_DataA,
    input  logic [31:0] rf_DataB,
    output logic [31:0] DataD,
    output logic [4:0]  AddrD,
    output logic        Reg_WE,
    output logic [31:0] DataA_fwd,
    output logic [31:0] DataB_fwd,
    output logic        ex_hazard,
    output logic [31:0] instret
);

    logic        wb_valid_q, wb_valid_d;
    logic        wb_we_q,    wb_we_d;
    logic [4:0]  wb_addrd_q, wb_addrd_d;
    logic [1:0]  wb_sel_q,   wb_sel_d;
    logic [2:0]  wb_f3_q,    wb_f3_d;
    logic [31:0] wb_alu_q,   wb_alu_d;
    logic [31:0] wb_pc_q,    wb_pc_d;
    logic [31:0] instret_q,  instret_d;

    // Stall holds every field; flush only turns the incoming entry into a bubble.
    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_we_d    = wb_we_q;
        wb_addrd_d = wb_addrd_q;
        wb_sel_d   = wb_sel_q;
        wb_f3_d    = wb_f3_q;
        wb_alu_d   = wb_alu_q;
        wb_pc_d    = wb_pc_q;
        instret_d  = instret_q;
        if (!stall) begin
            wb_valid_d = ex_valid & ~flush;
            wb_we_d    = ex_Reg_WE;
            wb_addrd_d = ex_AddrD;
            wb_sel_d   = ex_WBSel;
            wb_f3_d    = ex_funct3;
            wb_alu_d   = ex_alu;
            wb_pc_d    = ex_pc;
            if (wb_valid_q)
                instret_d = instret_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_addrd_q <= 5'd0;
            wb_sel_q   <= 2'b00;
            wb_f3_q    <= 3'b000;
            wb_alu_q   <= 32'd0;
            wb_pc_q    <= 32'd0;
            instret_q  <= 32'd0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_we_q    <= wb_we_d;
            wb_addrd_q <= wb_addrd_d;
            wb_sel_q   <= wb_sel_d;
            wb_f3_q    <= wb_f3_d;
            wb_alu_q   <= wb_alu_d;
            wb_pc_q    <= wb_pc_d;
            instret_q  <= instret_d;
        end
    end

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    always_comb begin
        ld_byte = mem_rdata[7:0];
        case (wb_alu_q[1:0])
            2'd0: ld_byte = mem_rdata[7:0];
            2'd1: ld_byte = mem_rdata[15:8];
            2'd2: ld_byte = mem_rdata[23:16];
            2'd3: ld_byte = mem_rdata[31:24];
            default: ld_byte = mem_rdata[7:0];
        endcase
        ld_half = wb_alu_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (wb_f3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    always_comb begin
        case (wb_sel_q)
            2'b01:   DataD = ld_data;
            2'b10:   DataD = wb_pc_q + 32'd4;
            default: DataD = wb_alu_q;
        endcase
    end

    logic wb_wr, match_a, match_b;

    assign wb_wr   = wb_valid_q & wb_we_q & (wb_addrd_q != 5'd0);
    assign match_a = wb_wr & (wb_addrd_q == AddrA);
    assign match_b = wb_wr & (wb_addrd_q == AddrB);

    assign AddrD   = wb_addrd_q;
    assign Reg_WE  = wb_wr & ~stall;
    assign instret = instret_q;

`ifdef WB_FWD_EN
    // Bypass ignores stall: the held WB result is still the youngest value.
    assign DataA_fwd = match_a ? DataD : rf_DataA;
    assign DataB_fwd = match_b ? DataD : rf_DataB;
    assign ex_hazard = 1'b0;
`else
    assign DataA_fwd = rf_DataA;
    assign DataB_fwd = rf_DataB;
    assign ex_hazard = match_a | match_b;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed vector table, stall/flush/reset sequences, random run vs model.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, ex_valid, ex_Reg_WE;
    logic [4:0]  ex_AddrD, AddrA, AddrB;
    logic [1:0]  ex_WBSel;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_alu, ex_pc, mem_rdata, rf_DataA, rf_DataB;
    logic [31:0] DataD, DataA_fwd, DataB_fwd, instret;
    logic [4:0]  AddrD;
    logic        Reg_WE, ex_hazard;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_Reg_WE(ex_Reg_WE), .ex_AddrD(ex_AddrD),
        .ex_WBSel(ex_WBSel), .ex_funct3(ex_funct3), .ex_alu(ex_alu), .ex_pc(ex_pc),
        .mem_rdata(mem_rdata), .AddrA(AddrA), .AddrB(AddrB),
        .rf_DataA(rf_DataA), .rf_DataB(rf_DataB),
        .DataD(DataD), .AddrD(AddrD), .Reg_WE(Reg_WE),
        .DataA_fwd(DataA_fwd), .DataB_fwd(DataB_fwd),
        .ex_hazard(ex_hazard), .instret(instret)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  ad;
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [31:0] rd;
        logic [31:0] exp_d;
        logic        exp_we;
    } vec_t;

    typedef struct {
        logic        valid;
        logic        we;
        logic [4:0]  ad;
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] pc;
    } ent_t;

    // Reference result computed from byte/halfword arithmetic on the memory word.
    function automatic logic [31:0] ref_result(input ent_t e, input logic [31:0] rd);
        int unsigned b, h;
        b = (rd >> (8 * e.alu[1:0])) & 32'hFF;
        h = (rd >> (16 * e.alu[1])) & 32'hFFFF;
        if (e.sel == 2'b10) return e.pc + 32'd4;
        if (e.sel != 2'b01) return e.alu;
        case (e.f3)
            3'b000:  return (b > 127) ? b + 32'hFFFFFF00 : b;
            3'b100:  return b;
            3'b001:  return (h > 32767) ? h + 32'hFFFF0000 : h;
            3'b101:  return h;
            default: return rd;
        endcase
    endfunction

    task automatic issue(input logic we, input logic [4:0] ad, input logic [1:0] sel,
                         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc);
        @(negedge clk);
        ex_valid = 1'b1; ex_Reg_WE = we; ex_AddrD = ad; ex_WBSel = sel;
        ex_funct3 = f3; ex_alu = alu; ex_pc = pc; stall = 1'b0; flush = 1'b0;
        @(negedge clk);
        ex_valid = 1'b0;
    endtask

    vec_t vecs[14];
    ent_t m;
    logic [31:0] m_inst;
    logic [31:0] exp_inst;
    logic        exp_we, exp_hz;
    logic [31:0] exp_fa, exp_fb;

    initial begin
        vecs[0]  = '{1, 5, 2'b00, 3'b000, 32'h12345678, 32'h0,        32'h0,        32'h12345678, 1};
        vecs[1]  = '{1, 6, 2'b01, 3'b000, 32'h00001001, 32'h0,        32'h80FF7F01, 32'h0000007F, 1};
        vecs[2]  = '{1, 6, 2'b01, 3'b000, 32'h00001002, 32'h0,        32'h80FF7F01, 32'hFFFFFFFF, 1};
        vecs[3]  = '{1, 6, 2'b01, 3'b101, 32'h00001002, 32'h0,        32'h80FF7F01, 32'h000080FF, 1};
        vecs[4]  = '{1, 6, 2'b01, 3'b001, 32'h00001002, 32'h0,        32'h80FF7F01, 32'hFFFF80FF, 1};
        vecs[5]  = '{1, 6, 2'b01, 3'b010, 32'h00001000, 32'h0,        32'h80FF7F01, 32'h80FF7F01, 1};
        vecs[6]  = '{1, 1, 2'b10, 3'b000, 32'h0,        32'h100,      32'h0,        32'h00000104, 1};
        vecs[7]  = '{1, 0, 2'b00, 3'b000, 32'h00000055, 32'h0,        32'h0,        32'h00000055, 0};
        vecs[8]  = '{1, 2, 2'b01, 3'b100, 32'h00000003, 32'h0,        32'h80FF7F01, 32'h00000080, 1};
        vecs[9]  = '{1, 3, 2'b11, 3'b000, 32'hCAFEBABE, 32'h0,        32'h0,        32'hCAFEBABE, 1};
        vecs[10] = '{0, 9, 2'b00, 3'b000, 32'h00000011, 32'h0,        32'h0,        32'h00000011, 0};
        vecs[11] = '{1, 4, 2'b01, 3'b001, 32'h00000001, 32'h0,        32'h80FF7F01, 32'h00007F01, 1};
        vecs[12] = '{1, 4, 2'b01, 3'b011, 32'h00000002, 32'h0,        32'h13579BDF, 32'h13579BDF, 1};
        vecs[13] = '{1, 8, 2'b10, 3'b000, 32'h0,        32'hFFFFFFFC, 32'h0,        32'h00000000, 1};

        rst = 1'b1; stall = 1'b0; flush = 1'b0; ex_valid = 1'b0; ex_Reg_WE = 1'b0;
        ex_AddrD = '0; ex_WBSel = '0; ex_funct3 = '0; ex_alu = '0; ex_pc = '0;
        mem_rdata = '0; AddrA = '0; AddrB = '0; rf_DataA = '0; rf_DataB = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_DataD", DataD, 32'h0);
        chk("rst_AddrD", {27'd0, AddrD}, 32'h0);
        chk("rst_Reg_WE", {31'd0, Reg_WE}, 32'h0);
        chk("rst_instret", instret, 32'h0);
        chk("rst_hazard", {31'd0, ex_hazard}, 32'h0);
        rst = 1'b0;

        // Vector table
        exp_inst = 32'd0;
        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].we, vecs[i].ad, vecs[i].sel, vecs[i].f3, vecs[i].alu, vecs[i].pc);
            mem_rdata = vecs[i].rd;
            #1;
            chk($sformatf("vec%0d_DataD", i), DataD, vecs[i].exp_d);
            chk($sformatf("vec%0d_Reg_WE", i), {31'd0, Reg_WE}, {31'd0, vecs[i].exp_we});
            chk($sformatf("vec%0d_AddrD", i), {27'd0, AddrD}, {27'd0, vecs[i].ad});
            chk($sformatf("vec%0d_instret", i), instret, exp_inst);
            exp_inst++;
        end

        // x0 destination never forwards / flags a hazard
        issue(1'b1, 5'd0, 2'b00, 3'b000, 32'h55, 32'h0);
        AddrA = 5'd0; rf_DataA = 32'h11; AddrB = 5'd0; rf_DataB = 32'h22; #1;
        chk("x0_fwdA", DataA_fwd, 32'h11);
        chk("x0_hazard", {31'd0, ex_hazard}, 32'h0);
        chk("x0_instret", instret, exp_inst);
        exp_inst++;

        // Forwarding / hazard on AddrA match, then held through a 3-cycle stall
        issue(1'b1, 5'd7, 2'b00, 3'b000, 32'h0000DEAD, 32'h0);
        AddrA = 5'd7; rf_DataA = 32'h0; AddrB = 5'd8; rf_DataB = 32'h5;
`ifdef WB_FWD_EN
        exp_fa = 32'hDEAD; exp_hz = 1'b0;
`else
        exp_fa = 32'h0; exp_hz = 1'b1;
`endif
        #1;
        chk("fwd_A", DataA_fwd, exp_fa);
        chk("fwd_B_nomatch", DataB_fwd, 32'h5);
        chk("fwd_hazard", {31'd0, ex_hazard}, {31'd0, exp_hz});
        stall = 1'b1; flush = 1'b1;
        ex_valid = 1'b1; ex_Reg_WE = 1'b1; ex_AddrD = 5'd4; ex_alu = 32'h4444;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall%0d_Reg_WE", k), {31'd0, Reg_WE}, 32'h0);
            chk($sformatf("stall%0d_AddrD", k), {27'd0, AddrD}, 32'd7);
            chk($sformatf("stall%0d_instret", k), instret, exp_inst);
            chk($sformatf("stall%0d_fwdA", k), DataA_fwd, exp_fa);
            @(negedge clk);
        end
        stall = 1'b0; #1;
        chk("release_Reg_WE", {31'd0, Reg_WE}, 32'h1);
        chk("release_AddrD", {27'd0, AddrD}, 32'd7);
        chk("release_DataD", DataD, 32'hDEAD);
        exp_inst++;
        @(negedge clk); #1;
        chk("flush_Reg_WE", {31'd0, Reg_WE}, 32'h0);
        chk("flush_instret", instret, exp_inst);
        flush = 1'b0; ex_valid = 1'b0;
        @(negedge clk); #1;
        chk("flush_no_commit", instret, exp_inst);

        // Reset in the middle of a stall discards the held entry
        issue(1'b1, 5'd9, 2'b00, 3'b000, 32'h77, 32'h0);
        stall = 1'b1; AddrA = 5'd9;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("rststall_DataD", DataD, 32'h0);
        chk("rststall_AddrD", {27'd0, AddrD}, 32'h0);
        chk("rststall_Reg_WE", {31'd0, Reg_WE}, 32'h0);
        chk("rststall_instret", instret, 32'h0);
        chk("rststall_hazard", {31'd0, ex_hazard}, 32'h0);
        rst = 1'b0; stall = 1'b0;
        @(negedge clk); #1;
        chk("rststall_no_write", instret, 32'h0);

        // Random run against the behavioural model
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m = '{0, 0, 0, 0, 0, 0, 0};
        m_inst = 32'd0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 63) == 0);
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 5) == 0);
            ex_valid = $urandom_range(0, 1);
            ex_Reg_WE = ($urandom_range(0, 3) != 0);
            ex_AddrD = 5'($urandom_range(0, 7));
            ex_WBSel = 2'($urandom);
            ex_funct3 = 3'($urandom);
            ex_alu = $urandom;
            ex_pc = $urandom;
            if (!stall) mem_rdata = $urandom;
            AddrA = ($urandom_range(0, 2) == 0) ? m.ad : 5'($urandom_range(0, 7));
            AddrB = ($urandom_range(0, 2) == 0) ? m.ad : 5'($urandom_range(0, 7));
            rf_DataA = $urandom;
            rf_DataB = $urandom;
            #1;
            exp_we = m.valid && m.we && (m.ad != 0) && !stall;
            exp_fa = rf_DataA; exp_fb = rf_DataB; exp_hz = 1'b0;
`ifdef WB_FWD_EN
            if (m.valid && m.we && m.ad != 0 && m.ad == AddrA) exp_fa = ref_result(m, mem_rdata);
            if (m.valid && m.we && m.ad != 0 && m.ad == AddrB) exp_fb = ref_result(m, mem_rdata);
`else
            exp_hz = m.valid && m.we && m.ad != 0 && (m.ad == AddrA || m.ad == AddrB);
`endif
            chk("rnd_Reg_WE", {31'd0, Reg_WE}, {31'd0, exp_we});
            chk("rnd_instret", instret, m_inst);
            chk("rnd_fwdA", DataA_fwd, exp_fa);
            chk("rnd_fwdB", DataB_fwd, exp_fb);
            chk("rnd_hazard", {31'd0, ex_hazard}, {31'd0, exp_hz});
            if (m.valid) begin
                chk("rnd_DataD", DataD, ref_result(m, mem_rdata));
                chk("rnd_AddrD", {27'd0, AddrD}, {27'd0, m.ad});
            end
            @(posedge clk);
            if (rst) begin
                m = '{0, 0, 0, 0, 0, 0, 0};
                m_inst = 32'd0;
            end else if (!stall) begin
                if (m.valid) m_inst = m_inst + 32'd1;
                m = '{ex_valid && !flush, ex_Reg_WE, ex_AddrD, ex_WBSel, ex_funct3, ex_alu, ex_pc};
            end
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
